snax_exercise_ctrl: RTL and testbench
=====================================

# snax_exercise_ctrl

Sequencing controller for the SNAX exercise dot-product PE. Software programs a job length and a 64-bit bias through CSR-facing ports. The controller then gates the PE's accelerator-ready input so that exactly the programmed number of result handshakes occur, and reports busy/done status and a result count back to the CSR manager. It sits between the CSR manager and the PE, alongside the data streamers that feed operands and drain results.

## Interface
- RegDataWidth, 32, width of CSR data, length, bias halves and counters.
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- csr_start_i  in  1  single-cycle start pulse.
- csr_len_i  in  RegDataWidth  number of results for the job, sampled on start.
- csr_upper_bias_i  in  RegDataWidth  upper bias word, sampled on start.
- csr_lower_bias_i  in  RegDataWidth  lower bias word, sampled on start.
- csr_clr_done_i  in  1  clears sticky done.
- busy_o  out  1  job in progress.
- done_o  out  1  sticky job-complete flag.
- res_cnt_o  out  RegDataWidth  results completed in current/last job.
- pe_acc_ready_o  out  1  drives PE acc_ready input.
- pe_out_valid_i  in  1  PE out_valid.
- pe_out_ready_i  in  1  downstream ready seen by PE.
- pe_upper_bias_o  out  RegDataWidth  latched upper bias to PE.
- pe_lower_bias_o  out  RegDataWidth  latched lower bias to PE.
- perf_cycles_o  out  RegDataWidth  busy-cycle counter (only with SNAX_EXERCISE_CTRL_PERF_EN).

## Operation
- FSM states: IDLE, RUN, DONE. Reset → IDLE.
- Reset values: busy_o=0, done_o=0, res_cnt_o=0, pe_acc_ready_o=0, bias outputs=0, perf_cycles_o=0.
- IDLE + start, len≠0 → RUN. Latch len and both bias words. Clear res_cnt.
- IDLE + start, len=0 → DONE directly. Latch bias. res_cnt=0.
- RUN: pe_acc_ready_o=1 (combinational from state). A result handshake is pe_out_valid_i & pe_out_ready_i & pe_acc_ready_o. Each handshake increments res_cnt.
- RUN, handshake with res_cnt = len−1 → DONE. res_cnt becomes len.
- DONE: done_o=1, busy_o=0, pe_acc_ready_o=0.
  - start with len≠0 → RUN.
  - start with len=0 stays in DONE and relatches bias.
  - otherwise clr_done_i → IDLE.
  - start takes precedence over clr_done_i in the same cycle.
- start during RUN is ignored. Latched len and bias are unchanged.
- clr_done_i outside DONE has no effect.
- busy_o = (state==RUN). done_o = (state==DONE).
- res_cnt is held after DONE until the next accepted start.
- Bias outputs hold their latched value until the next accepted start. CSR changes mid-job are not visible to the PE.

## Timing
- Start → pe_acc_ready_o high: 1 cycle (registered state).
- The last handshake occurs in cycle N. In cycle N+1, state=DONE, pe_acc_ready_o=0 and done_o=1. No extra handshake is possible.
- The controller never samples PE operand valids. Operand flow is gated solely through pe_acc_ready_o.
- Counter increments are unsigned and wrap modulo 2^RegDataWidth. Job length is capped by design at 2^RegDataWidth−1.
- Reset asserted mid-RUN returns to IDLE in the next cycle with all outputs at reset values. Any partial count is discarded.

## Configuration
- SNAX_EXERCISE_CTRL_PERF_EN defined:
  - perf_cycles_o exists.
  - It clears on an accepted start and increments every cycle in RUN.
  - It holds in IDLE/DONE and saturates at all-ones.
- Not defined: the port and the counter are absent. Other behaviour is identical.

## Structure
- Package snax_exercise_pkg holds:
  - ctrl_state_e enum (IDLE, RUN, DONE, 2-bit);
  - default RegDataWidth localparam;
  - BiasWidth = 2*RegDataWidth.
- Sub-module snax_exercise_ctrl_cnt: a loadable/clearable counter with enable and optional saturation. It is instantiated for res_cnt and for perf_cycles.

## Test plan
- Reset: hold rst_i 3 cycles → all outputs 0, state IDLE. PE ready stays 0 with pe_out_valid_i=1.
- Basic job: len=4, bias={0x1,0x2}, downstream always ready. Start → pe_acc_ready_o rises 1 cycle later, exactly 4 handshakes, then done_o=1, res_cnt_o=4, pe_acc_ready_o=0. Biases read 0x1/0x2 throughout.
- Backpressure: len=3, pe_out_ready_i toggled 1/0 → res_cnt_o counts only the cycles where valid&ready, and DONE follows the 3rd handshake. With PERF_EN, perf_cycles_o equals the number of RUN cycles.
- Zero length: start with len=0 → DONE the next cycle, res_cnt_o=0, no handshake ever.
- Ignored start and CSR change mid-RUN: start with len=5, len=9 and a new bias during RUN → exactly 5 results, bias unchanged. Then clr_done_i → IDLE.
- Reset mid-job and start/clear collision:
  - len=6, rst_i after 2 results → IDLE with outputs 0.
  - Rerun to DONE, then start (len=2) and clr_done_i in the same cycle → RUN, 2 results, DONE.

Source files
------------

// File: rtl/snax_exercise_pkg.sv
// Shared types and widths for the SNAX exercise PE sequencing controller.
package snax_exercise_pkg;

    localparam int RegDataWidth = 32;
    localparam int BiasWidth    = 2 * RegDataWidth;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/snax_exercise_ctrl_cnt.sv
// Loadable/clearable up-counter with enable; Saturate=1 holds at all-ones, else wraps.
module snax_exercise_ctrl_cnt #(
    parameter int Width    = 32,
    parameter bit Saturate = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             en_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] cnt_d, cnt_q;
    logic             at_max;

    assign at_max = Saturate && (cnt_q == {Width{1'b1}});

    // Clear wins over load, load wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && !at_max) begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/snax_exercise_ctrl.sv
// Job sequencer gating the PE acc_ready so exactly csr_len results are handshaked.
// Define SNAX_EXERCISE_CTRL_PERF_EN to add the saturating busy-cycle counter perf_cycles_o.
module snax_exercise_ctrl
    import snax_exercise_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    csr_start_i,
    input  logic [RegDataWidth-1:0] csr_len_i,
    input  logic [RegDataWidth-1:0] csr_upper_bias_i,
    input  logic [RegDataWidth-1:0] csr_lower_bias_i,
    input  logic                    csr_clr_done_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [RegDataWidth-1:0] res_cnt_o,
`ifdef SNAX_EXERCISE_CTRL_PERF_EN
    output logic [RegDataWidth-1:0] perf_cycles_o,
`endif
    output logic                    pe_acc_ready_o,
    input  logic                    pe_out_valid_i,
    input  logic                    pe_out_ready_i,
    output logic [RegDataWidth-1:0] pe_upper_bias_o,
    output logic [RegDataWidth-1:0] pe_lower_bias_o
);

    ctrl_state_e              state_d, state_q;
    logic [RegDataWidth-1:0]  len_d, len_q;
    logic [BiasWidth-1:0]     bias_d, bias_q;
    logic                     start_acc;
    logic                     hs;
    logic                     last_hs;

    // Starts are only honoured outside RUN so an in-flight job keeps its config.
    assign start_acc = csr_start_i && (state_q != RUN);
    assign hs        = pe_out_valid_i && pe_out_ready_i && pe_acc_ready_o;
    assign last_hs   = hs && (res_cnt_o == len_q - RegDataWidth'(1));

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        bias_d  = bias_q;
        if (start_acc) begin
            len_d   = csr_len_i;
            bias_d  = {csr_upper_bias_i, csr_lower_bias_i};
            state_d = (csr_len_i != '0) ? RUN : DONE;
        end else begin
            unique case (state_q)
                RUN:     if (last_hs) state_d = DONE;
                DONE:    if (csr_clr_done_i) state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            len_q   <= '0;
            bias_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            bias_q  <= bias_d;
        end
    end

    assign busy_o          = (state_q == RUN);
    assign done_o          = (state_q == DONE);
    assign pe_acc_ready_o  = (state_q == RUN);
    assign pe_upper_bias_o = bias_q[BiasWidth-1:RegDataWidth];
    assign pe_lower_bias_o = bias_q[RegDataWidth-1:0];

    snax_exercise_ctrl_cnt #(
        .Width    (RegDataWidth),
        .Saturate (1'b0)
    ) i_res_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (start_acc),
        .load_i     (1'b0),
        .load_val_i ('0),
        .en_i       (hs),
        .cnt_o      (res_cnt_o)
    );

`ifdef SNAX_EXERCISE_CTRL_PERF_EN
    snax_exercise_ctrl_cnt #(
        .Width    (RegDataWidth),
        .Saturate (1'b1)
    ) i_perf_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (start_acc),
        .load_i     (1'b0),
        .load_val_i ('0),
        .en_i       (busy_o),
        .cnt_o      (perf_cycles_o)
    );
`endif

endmodule

// File: tb/tb_snax_exercise_ctrl.sv
// Directed-vector bench for snax_exercise_ctrl: per-cycle table plus a backpressured job sequence.
module tb_snax_exercise_ctrl;
    import snax_exercise_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst_i = 1'b1;
    logic                    csr_start_i = 1'b0;
    logic [RegDataWidth-1:0] csr_len_i = '0;
    logic [RegDataWidth-1:0] csr_upper_bias_i = '0;
    logic [RegDataWidth-1:0] csr_lower_bias_i = '0;
    logic                    csr_clr_done_i = 1'b0;
    logic                    busy_o, done_o, pe_acc_ready_o;
    logic [RegDataWidth-1:0] res_cnt_o, pe_upper_bias_o, pe_lower_bias_o;
    logic                    pe_out_valid_i = 1'b0;
    logic                    pe_out_ready_i = 1'b0;
`ifdef SNAX_EXERCISE_CTRL_PERF_EN
    logic [RegDataWidth-1:0] perf_cycles_o;
`endif

    always #5 clk = ~clk;

    snax_exercise_ctrl dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .csr_start_i      (csr_start_i),
        .csr_len_i        (csr_len_i),
        .csr_upper_bias_i (csr_upper_bias_i),
        .csr_lower_bias_i (csr_lower_bias_i),
        .csr_clr_done_i   (csr_clr_done_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .res_cnt_o        (res_cnt_o),
`ifdef SNAX_EXERCISE_CTRL_PERF_EN
        .perf_cycles_o    (perf_cycles_o),
`endif
        .pe_acc_ready_o   (pe_acc_ready_o),
        .pe_out_valid_i   (pe_out_valid_i),
        .pe_out_ready_i   (pe_out_ready_i),
        .pe_upper_bias_o  (pe_upper_bias_o),
        .pe_lower_bias_o  (pe_lower_bias_o)
    );

    // One record = inputs held for one cycle, expected outputs just after that edge.
    typedef struct {
        string       name;
        logic        rst, start, clr, vld, rdy;
        logic [31:0] len, ub, lb;
        logic        e_busy, e_done, e_acc;
        logic [31:0] e_cnt, e_ub, e_lb;
    } vec_t;

    vec_t vq[$];
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic add(input string nm, input logic r, input logic s, input logic c,
                       input logic v, input logic y, input logic [31:0] l,
                       input logic [31:0] u, input logic [31:0] lo,
                       input logic eb, input logic ed, input logic ea,
                       input logic [31:0] ec, input logic [31:0] eu, input logic [31:0] el);
        vec_t t;
        t.name = nm; t.rst = r; t.start = s; t.clr = c; t.vld = v; t.rdy = y;
        t.len = l; t.ub = u; t.lb = lo;
        t.e_busy = eb; t.e_done = ed; t.e_acc = ea; t.e_cnt = ec; t.e_ub = eu; t.e_lb = el;
        vq.push_back(t);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    initial begin
        int hs_cnt, run_cyc, k;
        bit ok;

        //   name         rst st clr v r  len ub  lb     busy done acc cnt  ub  lb
        add("reset0",     1, 0, 0, 1, 1, 0, 0, 0,        0, 0, 0, 0, 0, 0);
        add("reset1",     1, 0, 0, 1, 1, 0, 0, 0,        0, 0, 0, 0, 0, 0);
        add("reset2",     1, 0, 0, 1, 1, 0, 0, 0,        0, 0, 0, 0, 0, 0);
        add("idle_vld",   0, 0, 0, 1, 1, 0, 0, 0,        0, 0, 0, 0, 0, 0);
        add("clr_idle",   0, 0, 1, 1, 1, 0, 0, 0,        0, 0, 0, 0, 0, 0);
        // basic len=4
        add("b_start",    0, 1, 0, 1, 1, 4, 1, 2,        1, 0, 1, 0, 1, 2);
        add("b_hs1",      0, 0, 0, 1, 1, 0, 0, 0,        1, 0, 1, 1, 1, 2);
        add("b_hs2",      0, 0, 0, 1, 1, 0, 0, 0,        1, 0, 1, 2, 1, 2);
        add("b_hs3",      0, 0, 0, 1, 1, 0, 0, 0,        1, 0, 1, 3, 1, 2);
        add("b_hs4",      0, 0, 0, 1, 1, 0, 0, 0,        0, 1, 0, 4, 1, 2);
        add("b_noextra",  0, 0, 0, 1, 1, 0, 0, 0,        0, 1, 0, 4, 1, 2);
        // backpressure len=3 started from DONE
        add("p_start",    0, 1, 0, 1, 1, 3, 'hA, 'hB,    1, 0, 1, 0, 'hA, 'hB);
        add("p_r1",       0, 0, 0, 1, 1, 0, 0, 0,        1, 0, 1, 1, 'hA, 'hB);
        add("p_r0",       0, 0, 0, 1, 0, 0, 0, 0,        1, 0, 1, 1, 'hA, 'hB);
        add("p_r1b",      0, 0, 0, 1, 1, 0, 0, 0,        1, 0, 1, 2, 'hA, 'hB);
        add("p_r0b",      0, 0, 0, 1, 0, 0, 0, 0,        1, 0, 1, 2, 'hA, 'hB);
        add("p_r1c",      0, 0, 0, 1, 1, 0, 0, 0,        0, 1, 0, 3, 'hA, 'hB);
        add("p_hold",     0, 0, 0, 1, 1, 0, 0, 0,        0, 1, 0, 3, 'hA, 'hB);
        // zero length
        add("z_start",    0, 1, 0, 1, 1, 0, 5, 6,        0, 1, 0, 0, 5, 6);
        add("z_hold",     0, 0, 0, 1, 1, 0, 0, 0,        0, 1, 0, 0, 5, 6);
        add("z_relatch",  0, 1, 0, 1, 1, 0, 7, 8,        0, 1, 0, 0, 7, 8);
        add("z_clr",      0, 0, 1, 1, 1, 0, 0, 0,        0, 0, 0, 0, 7, 8);
        add("z_idle0",    0, 1, 0, 0, 0, 0, 9, 9,        0, 1, 0, 0, 9, 9);
        add("z_clr2",     0, 0, 1, 0, 0, 0, 0, 0,        0, 0, 0, 0, 9, 9);
        // ignored start and CSR change mid-RUN, len=5
        add("i_start",    0, 1, 0, 1, 1, 5, 'h11, 'h22,  1, 0, 1, 0, 'h11, 'h22);
        add("i_hs1",      0, 0, 0, 1, 1, 0, 0, 0,        1, 0, 1, 1, 'h11, 'h22);
        add("i_restart",  0, 1, 0, 1, 1, 9, 'h33, 'h44,  1, 0, 1, 2, 'h11, 'h22);
        add("i_novld",    0, 0, 0, 0, 1, 9, 'h33, 'h44,  1, 0, 1, 2, 'h11, 'h22);
        add("i_clrrun",   0, 0, 1, 1, 1, 0, 0, 0,        1, 0, 1, 3, 'h11, 'h22);
        add("i_hs4",      0, 0, 0, 1, 1, 0, 0, 0,        1, 0, 1, 4, 'h11, 'h22);
        add("i_hs5",      0, 0, 0, 1, 1, 0, 0, 0,        0, 1, 0, 5, 'h11, 'h22);
        add("i_hold",     0, 0, 0, 1, 1, 0, 0, 0,        0, 1, 0, 5, 'h11, 'h22);
        add("i_clr",      0, 0, 1, 0, 0, 0, 0, 0,        0, 0, 0, 5, 'h11, 'h22);
        // reset mid-job, len=6
        add("r_start",    0, 1, 0, 1, 1, 6, 3, 4,        1, 0, 1, 0, 3, 4);
        add("r_hs1",      0, 0, 0, 1, 1, 0, 0, 0,        1, 0, 1, 1, 3, 4);
        add("r_hs2",      0, 0, 0, 1, 1, 0, 0, 0,        1, 0, 1, 2, 3, 4);
        add("r_rst",      1, 0, 0, 1, 1, 0, 0, 0,        0, 0, 0, 0, 0, 0);
        add("r_after",    0, 0, 0, 1, 1, 0, 0, 0,        0, 0, 0, 0, 0, 0);
        // rerun to DONE then start+clr collision
        add("c_start1",   0, 1, 0, 1, 1, 1, 'hC, 'hD,    1, 0, 1, 0, 'hC, 'hD);
        add("c_hs",       0, 0, 0, 1, 1, 0, 0, 0,        0, 1, 0, 1, 'hC, 'hD);
        add("c_collide",  0, 1, 1, 1, 1, 2, 'hE, 'hF,    1, 0, 1, 0, 'hE, 'hF);
        add("c_hs1",      0, 0, 0, 1, 1, 0, 0, 0,        1, 0, 1, 1, 'hE, 'hF);
        add("c_hs2",      0, 0, 0, 1, 1, 0, 0, 0,        0, 1, 0, 2, 'hE, 'hF);

        foreach (vq[i]) begin
            @(negedge clk);
            rst_i = vq[i].rst; csr_start_i = vq[i].start; csr_clr_done_i = vq[i].clr;
            pe_out_valid_i = vq[i].vld; pe_out_ready_i = vq[i].rdy;
            csr_len_i = vq[i].len; csr_upper_bias_i = vq[i].ub; csr_lower_bias_i = vq[i].lb;
            @(posedge clk); #1;
            n_chk++;
            ok = (busy_o === vq[i].e_busy) && (done_o === vq[i].e_done) &&
                 (pe_acc_ready_o === vq[i].e_acc) && (res_cnt_o === vq[i].e_cnt) &&
                 (pe_upper_bias_o === vq[i].e_ub) && (pe_lower_bias_o === vq[i].e_lb);
            if (ok) n_pass++;
            else $display("FAIL %s: got busy=%0b done=%0b acc=%0b cnt=%0d ub=%0h lb=%0h expected busy=%0b done=%0b acc=%0b cnt=%0d ub=%0h lb=%0h",
                          vq[i].name, busy_o, done_o, pe_acc_ready_o, res_cnt_o, pe_upper_bias_o, pe_lower_bias_o,
                          vq[i].e_busy, vq[i].e_done, vq[i].e_acc, vq[i].e_cnt, vq[i].e_ub, vq[i].e_lb);
        end

        // Backpressured len=7 job: count handshakes independently and bound the wait.
        @(negedge clk);
        csr_start_i = 1'b1; csr_clr_done_i = 1'b0; csr_len_i = 7;
        csr_upper_bias_i = 'h55; csr_lower_bias_i = 'h66;
        pe_out_valid_i = 1'b1; pe_out_ready_i = 1'b1;
        @(posedge clk); #1;
        hs_cnt = 0; run_cyc = 0; k = 0;
        while (busy_o === 1'b1 && k < 100) begin
            run_cyc++;
            @(negedge clk);
            csr_start_i = 1'b0;
            pe_out_valid_i = (k % 5) != 4;
            pe_out_ready_i = (k % 3) != 0;
            #1;
            if (pe_out_valid_i && pe_out_ready_i && pe_acc_ready_o) hs_cnt++;
            @(posedge clk); #1;
            k++;
        end
        check("seq_timeout", {31'd0, k < 100}, 32'd1);
        check("seq_done", {31'd0, done_o}, 32'd1);
        check("seq_acc_low", {31'd0, pe_acc_ready_o}, 32'd0);
        check("seq_hs", hs_cnt, 32'd7);
        check("seq_cnt", res_cnt_o, 32'd7);
        check("seq_ub", pe_upper_bias_o, 32'h55);
`ifdef SNAX_EXERCISE_CTRL_PERF_EN
        check("seq_perf", perf_cycles_o, run_cyc);
        @(negedge clk); @(posedge clk); #1;
        check("seq_perf_hold", perf_cycles_o, run_cyc);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
